// File: rtl/gpc_thread_pc_sched.sv
// rtl/gpc_thread_pc_sched.sv - round-robin barrel-thread PC scheduler feeding gpc fetch (Q100H) and tracking Q101H
// Optional per-thread issue counters are compiled in with GPC_THREAD_ISSUE_CNT_EN.
module gpc_thread_pc_sched #(
  parameter int              NUM_THREADS = 4,
  parameter int              PC_W        = 32,
  parameter longint unsigned RST_PC      = 64'h0,
  parameter longint unsigned PC_STRIDE   = 64'h400,
  localparam int             TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                   QClk,
  input  logic                   RstQnnnH,
  input  logic [NUM_THREADS-1:0] ThreadEnQnnnH,
  input  logic [NUM_THREADS-1:0] ThreadRstPcQnnnH,
  input  logic                   StallQnnnH,
  output logic [PC_W-1:0]        PcQ100H,
  output logic [TID_W-1:0]       ThreadIdQ100H,
  output logic                   ValidQ100H,
  output logic [PC_W-1:0]        PcQ101H,
  output logic [TID_W-1:0]       ThreadIdQ101H,
  output logic                   ValidQ101H,
  input  logic                   RedirectQ101H,
  input  logic [PC_W-1:0]        RedirectPcQ101H,
  input  logic                   FreezeQ101H
`ifdef GPC_THREAD_ISSUE_CNT_EN
  ,output logic [NUM_THREADS-1:0][31:0] IssueCntQnnnH
`endif
);

  logic [PC_W-1:0]        threadPc [NUM_THREADS];
  logic [PC_W-1:0]        rstPc    [NUM_THREADS];
  logic [TID_W-1:0]       lastTid;
  logic [NUM_THREADS-1:0] eligible;
  logic                   anyElig;
  logic                   issue;
  logic                   resolve;
  logic [TID_W-1:0]       sel;
  logic [PC_W-1:0]        selPc;
  logic [PC_W-1:0]        resolvePc;

  for (genvar g = 0; g < NUM_THREADS; g++) begin : gRstPc
    assign rstPc[g] = PC_W'(RST_PC + PC_STRIDE * 64'(g));
  end

  // A thread sitting in Q100H is skipped so no thread issues back-to-back.
  always_comb begin
    eligible = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      eligible[t] = ThreadEnQnnnH[t] && !ThreadRstPcQnnnH[t] &&
                    !(ValidQ100H && (ThreadIdQ100H == TID_W'(t)));
    end
  end

  // Scan from farthest to nearest so the first eligible after lastTid wins.
  always_comb begin
    anyElig = 1'b0;
    sel     = '0;
    for (int i = NUM_THREADS; i >= 1; i--) begin
      if (eligible[(int'(lastTid) + i) % NUM_THREADS]) begin
        anyElig = 1'b1;
        sel     = TID_W'((int'(lastTid) + i) % NUM_THREADS);
      end
    end
  end

  assign issue     = anyElig && !StallQnnnH;
  assign resolve   = ValidQ101H && (FreezeQ101H || RedirectQ101H);
  assign resolvePc = FreezeQ101H ? PcQ101H : RedirectPcQ101H;

  always_comb begin
    selPc = threadPc[sel];
    if (resolve && (ThreadIdQ101H == sel)) begin
      selPc = resolvePc;
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        threadPc[t] <= rstPc[t];
      end
      lastTid       <= TID_W'(NUM_THREADS - 1);
      PcQ100H       <= '0;
      ThreadIdQ100H <= '0;
      ValidQ100H    <= 1'b0;
      PcQ101H       <= '0;
      ThreadIdQ101H <= '0;
      ValidQ101H    <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (ThreadRstPcQnnnH[t]) begin
          threadPc[t] <= rstPc[t];
        end else if (issue && (sel == TID_W'(t))) begin
          threadPc[t] <= selPc + PC_W'(4);
        end else if (!StallQnnnH && resolve && (ThreadIdQ101H == TID_W'(t))) begin
          threadPc[t] <= resolvePc;
        end
      end
      if (!StallQnnnH) begin
        PcQ100H       <= issue ? selPc : '0;
        ThreadIdQ100H <= issue ? sel : '0;
        ValidQ100H    <= issue;
        if (issue) begin
          lastTid <= sel;
        end
        PcQ101H       <= PcQ100H;
        ThreadIdQ101H <= ThreadIdQ100H;
        ValidQ101H    <= ValidQ100H;
      end
    end
  end

`ifdef GPC_THREAD_ISSUE_CNT_EN
  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      IssueCntQnnnH <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (ThreadRstPcQnnnH[t]) begin
          IssueCntQnnnH[t] <= '0;
        end else if (issue && (sel == TID_W'(t)) && (IssueCntQnnnH[t] != 32'hFFFF_FFFF)) begin
          IssueCntQnnnH[t] <= IssueCntQnnnH[t] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_gpc_thread_pc_sched.sv
// tb/tb_gpc_thread_pc_sched.sv - table-driven scoreboard bench for gpc_thread_pc_sched
module tb_gpc_thread_pc_sched;
  localparam int NT  = 4;
  localparam int PCW = 32;
  localparam int TW  = 2;

  logic           QClk = 1'b0;
  logic           RstQnnnH;
  logic [NT-1:0]  ThreadEnQnnnH;
  logic [NT-1:0]  ThreadRstPcQnnnH;
  logic           StallQnnnH;
  logic [PCW-1:0] PcQ100H;
  logic [TW-1:0]  ThreadIdQ100H;
  logic           ValidQ100H;
  logic [PCW-1:0] PcQ101H;
  logic [TW-1:0]  ThreadIdQ101H;
  logic           ValidQ101H;
  logic           RedirectQ101H;
  logic [PCW-1:0] RedirectPcQ101H;
  logic           FreezeQ101H;
`ifdef GPC_THREAD_ISSUE_CNT_EN
  logic [NT-1:0][31:0] IssueCntQnnnH;
`endif

  gpc_thread_pc_sched #(.NUM_THREADS(NT), .PC_W(PCW)) dut (
    .QClk(QClk), .RstQnnnH(RstQnnnH),
    .ThreadEnQnnnH(ThreadEnQnnnH), .ThreadRstPcQnnnH(ThreadRstPcQnnnH),
    .StallQnnnH(StallQnnnH),
    .PcQ100H(PcQ100H), .ThreadIdQ100H(ThreadIdQ100H), .ValidQ100H(ValidQ100H),
    .PcQ101H(PcQ101H), .ThreadIdQ101H(ThreadIdQ101H), .ValidQ101H(ValidQ101H),
    .RedirectQ101H(RedirectQ101H), .RedirectPcQ101H(RedirectPcQ101H),
    .FreezeQ101H(FreezeQ101H)
`ifdef GPC_THREAD_ISSUE_CNT_EN
    , .IssueCntQnnnH(IssueCntQnnnH)
`endif
  );

  always #5 QClk = ~QClk;

  typedef struct {
    logic [NT-1:0]  en;
    logic           stall;
    logic           red;
    logic [PCW-1:0] redPc;
    logic           frz;
    logic [NT-1:0]  rst;
    logic           expV;
    logic [TW-1:0]  expTid;
    logic [PCW-1:0] expPc;
  } vec_t;

  typedef struct {
    logic           v;
    logic [TW-1:0]  tid;
    logic [PCW-1:0] pc;
  } slot_t;

  slot_t expQ[$];
  slot_t prev100;
  slot_t exp101;
  vec_t  tblA[$];
  vec_t  tblB[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [NT-1:0] en, input logic stall, input logic red,
                              input logic [PCW-1:0] redPc, input logic frz, input logic [NT-1:0] rst,
                              input logic expV, input logic [TW-1:0] expTid, input logic [PCW-1:0] expPc);
    vec_t v;
    v.en = en; v.stall = stall; v.red = red; v.redPc = redPc; v.frz = frz; v.rst = rst;
    v.expV = expV; v.expTid = expTid; v.expPc = expPc;
    return v;
  endfunction

  task automatic checkZero(input string tag);
    chk({tag, ".v100"},   32'(ValidQ100H),    32'h0);
    chk({tag, ".tid100"}, 32'(ThreadIdQ100H), 32'h0);
    chk({tag, ".pc100"},  PcQ100H,            32'h0);
    chk({tag, ".v101"},   32'(ValidQ101H),    32'h0);
    chk({tag, ".tid101"}, 32'(ThreadIdQ101H), 32'h0);
    chk({tag, ".pc101"},  PcQ101H,            32'h0);
  endtask

  task automatic runVec(input vec_t v, input string tag);
    slot_t e;
    slot_t pushed;
    ThreadEnQnnnH    = v.en;
    StallQnnnH       = v.stall;
    RedirectQ101H    = v.red;
    RedirectPcQ101H  = v.redPc;
    FreezeQ101H      = v.frz;
    ThreadRstPcQnnnH = v.rst;
    pushed.v = v.expV; pushed.tid = v.expTid; pushed.pc = v.expPc;
    expQ.push_back(pushed);
    @(posedge QClk);
    #1;
    e = expQ.pop_front();
    if (!v.stall) begin
      exp101  = prev100;
      prev100 = e;
    end
    chk({tag, ".v100"},   32'(ValidQ100H),    32'(e.v));
    chk({tag, ".tid100"}, 32'(ThreadIdQ100H), 32'(e.tid));
    chk({tag, ".pc100"},  PcQ100H,            e.pc);
    chk({tag, ".v101"},   32'(ValidQ101H),    32'(exp101.v));
    chk({tag, ".tid101"}, 32'(ThreadIdQ101H), 32'(exp101.tid));
    chk({tag, ".pc101"},  PcQ101H,            exp101.pc);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Round robin, redirect, freeze+redirect, stall, per-thread reset vs redirect
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 0, 32'h0));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 1, 32'h400));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 2, 32'h800));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 3, 32'hC00));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 0, 32'h4));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 1, 32'h404));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 2, 32'h804));
    tblA.push_back(mk(4'hF, 0, 1, 32'h1234, 0, 4'h0, 1, 3, 32'hC04));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 0, 32'h8));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 1, 32'h1234));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 2, 32'h808));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 3, 32'hC08));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 0, 32'hC));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 1, 32'h1238));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 2, 32'h80C));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 3, 32'hC0C));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 0, 32'h10));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 1, 32'h123C));
    tblA.push_back(mk(4'hF, 0, 1, 32'h5555, 1, 4'h0, 1, 2, 32'h810));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 3, 32'hC10));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 0, 32'h10));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 1, 32'h1240));
    tblA.push_back(mk(4'hF, 1, 1, 32'h2000, 0, 4'h0, 1, 1, 32'h1240));
    tblA.push_back(mk(4'hF, 1, 1, 32'h2000, 0, 4'h0, 1, 1, 32'h1240));
    tblA.push_back(mk(4'hF, 1, 1, 32'h2000, 0, 4'h0, 1, 1, 32'h1240));
    tblA.push_back(mk(4'hF, 0, 1, 32'h2000, 0, 4'h0, 1, 2, 32'h814));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 3, 32'hC14));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 0, 32'h2000));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 1, 32'h1244));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 2, 32'h818));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 3, 32'hC18));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 0, 32'h2004));
    tblA.push_back(mk(4'hF, 0, 1, 32'h3333, 0, 4'h8, 1, 1, 32'h1248));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 2, 32'h81C));
    tblA.push_back(mk(4'hF, 0, 0, 0,        0, 4'h0, 1, 3, 32'hC00));

    // Single thread: alternating bubbles and the redirect bypass path
    tblB.push_back(mk(4'h4, 0, 0, 0,        0, 4'h0, 1, 2, 32'h800));
    tblB.push_back(mk(4'h4, 0, 0, 0,        0, 4'h0, 0, 0, 32'h0));
    tblB.push_back(mk(4'h4, 0, 0, 0,        0, 4'h0, 1, 2, 32'h804));
    tblB.push_back(mk(4'h4, 0, 0, 0,        0, 4'h0, 0, 0, 32'h0));
    tblB.push_back(mk(4'h4, 0, 0, 0,        0, 4'h0, 1, 2, 32'h808));
    tblB.push_back(mk(4'h4, 0, 0, 0,        0, 4'h0, 0, 0, 32'h0));
    tblB.push_back(mk(4'h4, 0, 1, 32'h1234, 0, 4'h0, 1, 2, 32'h1234));
    tblB.push_back(mk(4'h4, 0, 0, 0,        0, 4'h0, 0, 0, 32'h0));
    tblB.push_back(mk(4'h4, 0, 0, 0,        0, 4'h0, 1, 2, 32'h1238));

    RstQnnnH = 1'b0;
    ThreadEnQnnnH = '0; ThreadRstPcQnnnH = '0; StallQnnnH = 1'b0;
    RedirectQ101H = 1'b0; RedirectPcQ101H = '0; FreezeQ101H = 1'b0;
    prev100 = '{1'b0, '0, '0};
    exp101  = '{1'b0, '0, '0};
    repeat (2) @(posedge QClk);
    #1;
    checkZero("rst0");

    RstQnnnH = 1'b1;
    for (int i = 0; i < tblA.size(); i++) begin
      runVec(tblA[i], $sformatf("a%0d", i + 1));
    end

    // Async reset mid-stream must clear outputs without a clock edge
    RstQnnnH = 1'b0;
    #1;
    checkZero("arst");
    prev100 = '{1'b0, '0, '0};
    exp101  = '{1'b0, '0, '0};
    @(posedge QClk);
    #1;
    RstQnnnH = 1'b1;
    for (int i = 0; i < tblB.size(); i++) begin
      runVec(tblB[i], $sformatf("b%0d", i + 1));
    end

`ifdef GPC_THREAD_ISSUE_CNT_EN
    chk("cnt2", IssueCntQnnnH[2], 32'd5);
    chk("cnt0", IssueCntQnnnH[0], 32'd0);
`endif

    chk("sbEmpty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
